// File: rtl/axi4_lite_wr.sv
// ---------------------------------------------------------------------------
// axi4_lite_wr
//
// Single-beat AXI4-Lite write master. A user request (address, data, byte
// strobes) accepted on a valid/ready handshake is issued on the AW and W
// channels. The B response is then collected and returned to the user as a
// one-cycle wr_done pulse with wr_resp.
//
// Handshake rule for every valid/ready pair in this block: a transfer
// happens on the rising edge where valid && ready are both high. A valid
// output, once raised, stays high with stable payload until that edge.
//
// Ports
//   clk, rst         : clock; synchronous active-high reset
//   wr_addr/data/strb: user request payload, sampled on accept
//   wr_valid/ready   : user request handshake (ready only in SM_IDLE)
//   wr_done          : one-cycle pulse when the B response arrives
//   wr_resp          : BRESP of the last completed write (held)
//   wr_timeout       : sticky stall flag, cleared on the next accept
//   s_axi_aw*        : AXI4-Lite write address channel
//   s_axi_w*         : AXI4-Lite write data channel
//   s_axi_b*         : AXI4-Lite write response channel
//   dbg_state        : current one-hot FSM state
// ---------------------------------------------------------------------------
module axi4_lite_wr #(
  parameter int TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic        wr_done,
  output logic [1:0]  wr_resp,
  output logic        wr_timeout,
  output logic [31:0] s_axi_awaddr,
  output logic        s_axi_awvalid,
  input  logic        s_axi_awready,
  output logic [31:0] s_axi_wdata,
  output logic [3:0]  s_axi_wstrb,
  output logic        s_axi_wvalid,
  input  logic        s_axi_wready,
  input  logic [1:0]  s_axi_bresp,
  input  logic        s_axi_bvalid,
  output logic        s_axi_bready,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    SM_IDLE         = 3'b001,
    SM_WR_ADDR_DATA = 3'b010,
    SM_WT_RESP      = 3'b100
  } state_e;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  state_e        state_q,   state_d;
  logic [31:0]   awaddr_q,  awaddr_d;
  logic [31:0]   wdata_q,   wdata_d;
  logic [3:0]    wstrb_q,   wstrb_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q,  wvalid_d;
  logic          bready_q,  bready_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q,  w_done_d;
  logic          wr_done_q, wr_done_d;
  logic [1:0]    wr_resp_q, wr_resp_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] cnt_q,     cnt_d;

  logic aw_hs;
  logic w_hs;
  logic b_hs;

  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    wr_done_d = 1'b0;
    wr_resp_d = wr_resp_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;

    aw_hs = awvalid_q && s_axi_awready;
    w_hs  = wvalid_q  && s_axi_wready;
    b_hs  = bready_q  && s_axi_bvalid;

    unique case (state_q)
      SM_IDLE: begin
        if (wr_valid) begin
          awaddr_d  = wr_addr;
          wdata_d   = wr_data;
          wstrb_d   = wr_strb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          state_d   = SM_WR_ADDR_DATA;
        end
      end
      SM_WR_ADDR_DATA: begin
        // AW and W complete independently; the _d flags already include a
        // handshake happening on this edge, so the same-cycle case moves on.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = SM_WT_RESP;
        end
      end
      SM_WT_RESP: begin
        if (b_hs) begin
          wr_resp_d = s_axi_bresp;
          wr_done_d = 1'b1;
          bready_d  = 1'b0;
          state_d   = SM_IDLE;
        end
      end
      default: begin
        state_d = SM_IDLE;
      end
    endcase

    // Stall counter: restarts on any channel handshake, saturates at
    // TIMEOUT. The flag only reports; the AXI transaction is never aborted.
    if (TIMEOUT > 0 && state_q != SM_IDLE) begin
      if (aw_hs || w_hs || b_hs) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_d == CNT_MAX) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SM_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wr_done_q <= 1'b0;
      wr_resp_q <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      wr_done_q <= wr_done_d;
      wr_resp_q <= wr_resp_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wr_ready      = (state_q == SM_IDLE);
  assign wr_done       = wr_done_q;
  assign wr_resp       = wr_resp_q;
  assign wr_timeout    = timeout_q;
  assign s_axi_awaddr  = awaddr_q;
  assign s_axi_awvalid = awvalid_q;
  assign s_axi_wdata   = wdata_q;
  assign s_axi_wstrb   = wstrb_q;
  assign s_axi_wvalid  = wvalid_q;
  assign s_axi_bready  = bready_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_axi4_lite_wr.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_wr
//
// Directed bench for axi4_lite_wr (TIMEOUT=8). Inputs change 1 ns after the
// rising edge; DUT outputs are examined at that same point, and the AW
// monitor samples on the falling edge.
// ---------------------------------------------------------------------------
module tb_axi4_lite_wr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic        wr_done;
  logic [1:0]  wr_resp;
  logic        wr_timeout;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready = 1'b0;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready = 1'b0;
  logic [1:0]  s_axi_bresp = 2'b00;
  logic        s_axi_bvalid = 1'b0;
  logic        s_axi_bready;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int aw_hs_cnt = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  axi4_lite_wr #(.TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_strb      (wr_strb),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_done      (wr_done),
    .wr_resp      (wr_resp),
    .wr_timeout   (wr_timeout),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // AW scoreboard and wr_done counter.
  always @(negedge clk) begin
    if (!rst) begin
      if (s_axi_awvalid && s_axi_awready) begin
        aw_hs_cnt++;
        if (exp_q.size() > 0) chk("aw_addr", s_axi_awaddr, exp_q.pop_front());
        else chk("aw_unexpected", 32'd1, 32'd0);
      end
      if (wr_done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in the cycle right after the accepting edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    while (!wr_ready && n < 50) begin
      tick();
      n++;
    end
    if (!wr_ready) chk("accept_wait", 32'd0, 32'd1);
    wr_addr  = a;
    wr_data  = d;
    wr_strb  = s;
    wr_valid = 1'b1;
    exp_q.push_back(a);
    tick();
    wr_valid = 1'b0;
  endtask

  // Returns in the wr_done cycle (or after the budget expires).
  task automatic wait_done(input int max_cyc, input string tag);
    int n = 0;
    while (!wr_done && n < max_cyc) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, wr_done}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int aw_cyc, w_cyc, d0, a0, idx, cyc, n;
  int acc[3];
  logic [31:0] b2b[3];

  initial begin
    b2b[0] = 32'h0000_0100;
    b2b[1] = 32'h0000_0204;
    b2b[2] = 32'h0000_0308;

    // reset
    tick();
    tick();
    chk("rst_awvalid", {31'd0, s_axi_awvalid}, 32'd0);
    chk("rst_wvalid",  {31'd0, s_axi_wvalid},  32'd0);
    chk("rst_bready",  {31'd0, s_axi_bready},  32'd0);
    chk("rst_done",    {31'd0, wr_done},       32'd0);
    chk("rst_timeout", {31'd0, wr_timeout},    32'd0);
    chk("rst_awaddr",  s_axi_awaddr,           32'd0);
    chk("rst_wdata",   s_axi_wdata,            32'd0);
    chk("rst_wstrb",   {28'd0, s_axi_wstrb},   32'd0);
    chk("rst_resp",    {30'd0, wr_resp},       32'd0);
    chk("rst_state",   {29'd0, dbg_state},     32'd1);
    rst = 1'b0;
    tick();
    chk("rst_ready", {31'd0, wr_ready}, 32'd1);

    // T1: always-ready slave, minimum latency
    s_axi_awready = 1'b1;
    s_axi_wready  = 1'b1;
    s_axi_bvalid  = 1'b1;
    s_axi_bresp   = 2'b00;
    chk("t1_ready_n", {31'd0, wr_ready}, 32'd1);
    do_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    chk("t1_awvalid_n1", {31'd0, s_axi_awvalid}, 32'd1);
    chk("t1_wvalid_n1",  {31'd0, s_axi_wvalid},  32'd1);
    chk("t1_awaddr",     s_axi_awaddr,           32'h0000_0010);
    chk("t1_wdata",      s_axi_wdata,            32'hDEAD_BEEF);
    chk("t1_wstrb",      {28'd0, s_axi_wstrb},   32'hF);
    chk("t1_bready_n1",  {31'd0, s_axi_bready},  32'd0);
    chk("t1_ready_n1",   {31'd0, wr_ready},      32'd0);
    tick();
    chk("t1_awvalid_n2", {31'd0, s_axi_awvalid}, 32'd0);
    chk("t1_wvalid_n2",  {31'd0, s_axi_wvalid},  32'd0);
    chk("t1_bready_n2",  {31'd0, s_axi_bready},  32'd1);
    chk("t1_done_n2",    {31'd0, wr_done},       32'd0);
    tick();
    chk("t1_done_n3",    {31'd0, wr_done},       32'd1);
    chk("t1_resp_n3",    {30'd0, wr_resp},       32'd0);
    chk("t1_ready_n3",   {31'd0, wr_ready},      32'd1);
    chk("t1_bready_n3",  {31'd0, s_axi_bready},  32'd0);
    tick();
    chk("t1_done_n4",    {31'd0, wr_done},       32'd0);

    // T2: awready delayed 4 cycles, wready immediate, bvalid held early
    s_axi_awready = 1'b0;
    do_write(32'h0000_0020, 32'h1234_5678, 4'h3);
    aw_cyc = 0;
    w_cyc  = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 5) s_axi_awready = 1'b1;
      if (s_axi_awvalid) begin
        aw_cyc++;
        chk("t2_awaddr_stable", s_axi_awaddr, 32'h0000_0020);
      end
      if (s_axi_wvalid) w_cyc++;
      chk("t2_no_early_done", {31'd0, wr_done}, 32'd0);
      if (k == 5) chk("t2_bready_before", {31'd0, s_axi_bready}, 32'd0);
      if (k == 6) chk("t2_bready_after",  {31'd0, s_axi_bready}, 32'd1);
      tick();
    end
    chk("t2_aw_cycles", aw_cyc, 32'd5);
    chk("t2_w_cycles",  w_cyc,  32'd1);
    chk("t2_done",      {31'd0, wr_done}, 32'd1);

    // T3: wready delayed 3 cycles, SLVERR response held across next write
    s_axi_wready = 1'b0;
    s_axi_bresp  = 2'b10;
    do_write(32'h0000_0030, 32'hCAFE_F00D, 4'h5);
    for (int k = 1; k <= 5; k++) begin
      if (k == 4) s_axi_wready = 1'b1;
      tick();
    end
    chk("t3_done", {31'd0, wr_done}, 32'd1);
    chk("t3_resp", {30'd0, wr_resp}, 32'd2);
    s_axi_bresp = 2'b00;
    do_write(32'h0000_0034, 32'h0000_0001, 4'h1);
    chk("t3_resp_hold1", {30'd0, wr_resp}, 32'd2);
    tick();
    chk("t3_resp_hold2", {30'd0, wr_resp}, 32'd2);
    tick();
    chk("t3_done2", {31'd0, wr_done}, 32'd1);
    chk("t3_resp2", {30'd0, wr_resp}, 32'd0);

    // T4: stall for 20 cycles, timeout flag, normal completion, clear
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    do_write(32'h0000_0040, 32'h5555_AAAA, 4'hF);
    for (int k = 1; k <= 20; k++) begin
      if (k == 7) chk("t4_timeout_early", {31'd0, wr_timeout}, 32'd0);
      if (k == 9) chk("t4_timeout_set",   {31'd0, wr_timeout}, 32'd1);
      if (k == 20) begin
        chk("t4_timeout_held", {31'd0, wr_timeout},    32'd1);
        chk("t4_awvalid_held", {31'd0, s_axi_awvalid}, 32'd1);
        chk("t4_wvalid_held",  {31'd0, s_axi_wvalid},  32'd1);
        s_axi_awready = 1'b1;
        s_axi_wready  = 1'b1;
      end
      tick();
    end
    wait_done(5, "t4_done");
    chk("t4_timeout_sticky", {31'd0, wr_timeout}, 32'd1);
    tick();
    do_write(32'h0000_0044, 32'h0000_0002, 4'h2);
    chk("t4_timeout_clear", {31'd0, wr_timeout}, 32'd0);
    wait_done(5, "t4_done2");

    // T5: reset while waiting for the response
    s_axi_bvalid = 1'b0;
    tick();
    do_write(32'h0000_0050, 32'h0000_0003, 4'h8);
    tick();
    chk("t5_bready_pre", {31'd0, s_axi_bready}, 32'd1);
    chk("t5_state_pre",  {29'd0, dbg_state},    32'd4);
    d0  = done_cnt;
    rst = 1'b1;
    tick();
    chk("t5_awvalid", {31'd0, s_axi_awvalid}, 32'd0);
    chk("t5_wvalid",  {31'd0, s_axi_wvalid},  32'd0);
    chk("t5_bready",  {31'd0, s_axi_bready},  32'd0);
    chk("t5_ready",   {31'd0, wr_ready},      32'd1);
    chk("t5_done",    {31'd0, wr_done},       32'd0);
    rst = 1'b0;
    s_axi_bvalid = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("t5_no_done", done_cnt - d0, 32'd0);

    // T6: back-to-back requests with wr_valid held high
    a0  = aw_hs_cnt;
    d0  = done_cnt;
    idx = 0;
    cyc = 0;
    for (int i = 0; i < 3; i++) exp_q.push_back(b2b[i]);
    wr_addr  = b2b[0];
    wr_data  = 32'hB0B0_0000;
    wr_strb  = 4'hF;
    wr_valid = 1'b1;
    while (idx < 3 && cyc < 40) begin
      if (wr_ready) begin
        acc[idx] = cyc;
        idx++;
      end
      tick();
      cyc++;
      if (idx < 3) begin
        wr_addr = b2b[idx];
        wr_data = 32'hB0B0_0000 + idx;
      end else begin
        wr_valid = 1'b0;
      end
    end
    wr_valid = 1'b0;
    chk("t6_accepts", idx, 32'd3);
    n = 0;
    while ((done_cnt - d0) < 3 && n < 20) begin
      tick();
      n++;
    end
    tick();
    chk("t6_aw_count",   aw_hs_cnt - a0, 32'd3);
    chk("t6_done_count", done_cnt - d0,  32'd3);
    chk("t6_gap01", {31'd0, (acc[1] - acc[0]) >= 3}, 32'd1);
    chk("t6_gap12", {31'd0, (acc[2] - acc[1]) >= 3}, 32'd1);
    chk("aw_queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
